// File: rtl/fnn_pkg.sv
// Shared types, constants and the saturating adder for the fractal neuron sequencer.
package fnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SYN_PER_BEAT = 4;
  localparam int ZERO_BIT     = 0;
  localparam int SIGN_BIT     = 1;

  // Adds in 32 bits and clamps to the signed range of a width-bit register.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] res;
    sum = a + b;
    hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 1));
    if (sum > hi) begin
      res = hi;
    end else if (sum < lo) begin
      res = lo;
    end else begin
      res = sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/synapse4_sum.sv
// Combinational 4-synapse ternary multiply-add; result range is -4..+4.
module synapse4_sum
  import fnn_pkg::*;
(
  input  logic       [3:0] in_x,
  input  logic       [7:0] in_w,
  output logic signed [3:0] sum
);

  logic signed [1:0] y [SYN_PER_BEAT];

  for (genvar i = 0; i < SYN_PER_BEAT; i++) begin : g_syn
    synapse_mul u_mul (
      .x    (in_x[i]),
      .zero (in_w[2*i + ZERO_BIT]),
      .sign (in_w[2*i + SIGN_BIT]),
      .y    (y[i])
    );
  end

  assign sum = 4'(y[0]) + 4'(y[1]) + 4'(y[2]) + 4'(y[3]);

endmodule

// File: rtl/synapse_mul.sv
// Single ternary synapse: input bit times a {-1, 0, +1} weight.
module synapse_mul (
  input  logic              x,
  input  logic              zero,
  input  logic              sign,
  output logic signed [1:0] y
);

  assign y = (!x || zero) ? 2'sb00 : (sign ? 2'sb11 : 2'sb01);

endmodule

// File: rtl/fractal_neuron_sequencer.sv
// Time-multiplexes one 4-synapse slice across NUM_INPUTS/4 beats, accumulating into a
// saturating signed accumulator and comparing the total against a captured threshold.
module fractal_neuron_sequencer
  import fnn_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int ACC_W      = 8,
  parameter int THR_W      = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [THR_W-1:0] threshold,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [3:0]       in_x,
  input  logic        [7:0]       in_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_fire,
  output logic                    busy
);

  localparam int NUM_BEATS = NUM_INPUTS / SYN_PER_BEAT;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  state_t                    state;
  state_t                    state_nxt;
  state_t                    flow_nxt;
  logic        [CNT_W-1:0]   count;
  logic signed [3:0]         beat_sum;
  logic signed [3:0]         psum;
  logic                      psum_valid;
  logic signed [ACC_W-1:0]   acc;
  logic signed [THR_W-1:0]   thr;
  logic                      accept;

  synapse4_sum u_sum (
    .in_x (in_x),
    .in_w (in_w),
    .sum  (beat_sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; abort overrides the normal flow.
  always_comb begin
    flow_nxt = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        flow_nxt = start ? ACCUM : IDLE;
      end
      ACCUM: begin
        in_ready = 1'b1;
        flow_nxt = (in_valid && (count == LAST_BEAT)) ? DRAIN : ACCUM;
      end
      DRAIN: begin
        flow_nxt = DONE;
      end
      DONE: begin
        flow_nxt = (out_valid && out_ready) ? IDLE : DONE;
      end
      default: begin
        flow_nxt = IDLE;
      end
    endcase
    state_nxt = abort ? IDLE : flow_nxt;
    accept    = in_valid && in_ready && !abort;
  end

  // Beat capture, accumulation pipeline and threshold capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      count      <= '0;
      psum       <= 4'sd0;
      psum_valid <= 1'b0;
      thr        <= '0;
    end else if (abort) begin
      acc        <= '0;
      count      <= '0;
      psum_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        acc   <= '0;
        count <= '0;
        thr   <= threshold;
      end else begin
        if (psum_valid) begin
          acc <= ACC_W'(sat_add(32'(acc), 32'(psum), ACC_W));
        end
        if (accept) begin
          count <= count + CNT_W'(1);
        end
      end
      psum_valid <= accept;
      if (accept) begin
        psum <= beat_sum;
      end
    end
  end

  // Result registers: loaded on the first DONE cycle, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
    end else if ((state == DONE) && !out_valid) begin
      out_valid <= 1'b1;
      out_sum   <= acc;
      out_fire  <= (acc >= thr);
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fractal_neuron_sequencer.sv
// Randomized self-checking bench: two instances (ACC_W=8 and ACC_W=5) share stimulus and
// are compared against a per-beat saturating dot-product model.
module tb_fractal_neuron_sequencer;

  localparam int NB = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic signed [7:0] threshold = 8'sd0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic        [3:0] in_x = 4'h0;
  logic        [7:0] in_w = 8'h00;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid, out_fire, busy;
  logic signed [7:0] out_sum;
  logic              in_ready5, out_valid5, out_fire5, busy5;
  logic signed [4:0] out_sum5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] bx [NB];
  logic [7:0] bw [NB];

  always #5 clk = ~clk;

  fractal_neuron_sequencer #(.NUM_INPUTS(16), .ACC_W(8), .THR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_fire(out_fire), .busy(busy)
  );

  fractal_neuron_sequencer #(.NUM_INPUTS(16), .ACC_W(5), .THR_W(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold[4:0]), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready5), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid5), .out_ready(out_ready), .out_sum(out_sum5),
    .out_fire(out_fire5), .busy(busy5)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int beat_value(input logic [3:0] x, input logic [7:0] w);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      if (x[i] && !w[2*i]) s += w[2*i+1] ? -1 : 1;
    end
    return s;
  endfunction

  // Running sum clamped after every beat, as a width-bit register would hold it.
  function automatic int model_sum(input int width);
    int acc = 0;
    int hi = (1 << (width - 1)) - 1;
    int lo = -(1 << (width - 1));
    for (int b = 0; b < NB; b++) begin
      acc += beat_value(bx[b], bw[b]);
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    return acc;
  endfunction

  function automatic int wrap5(input int t);
    int v = t & 31;
    return (v >= 16) ? v - 32 : v;
  endfunction

  task automatic set_all(input logic [3:0] x, input logic [7:0] w);
    for (int b = 0; b < NB; b++) begin
      bx[b] = x;
      bw[b] = w;
    end
  endtask

  task automatic set_random();
    for (int b = 0; b < NB; b++) begin
      bx[b] = 4'($urandom);
      bw[b] = 8'($urandom);
    end
  endtask

  task automatic do_start(input int thr);
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 0);
    threshold = 8'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    threshold = 8'($urandom);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic feed(input int nbeats, input bit gappy);
    int b = 0;
    int guard = 0;
    while (b < nbeats && guard < 64) begin
      bit v;
      v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      check("accum_in_ready", int'(in_ready), 1);
      in_valid = v;
      in_x = v ? bx[b] : 4'($urandom);
      in_w = v ? bw[b] : 8'($urandom);
      @(negedge clk);
      if (v) b++;
      guard++;
    end
    if (b < nbeats) check("beat_timeout", b, nbeats);
    in_valid = 1'b0;
    in_x = 4'($urandom);
    in_w = 8'($urandom);
  endtask

  task automatic run_eval(input int thr, input bit gappy, input int hold);
    int exp8, exp5, t5, s8, s5;
    bit f8, f5;
    exp8 = model_sum(8);
    exp5 = model_sum(5);
    t5   = wrap5(thr);
    do_start(thr);
    feed(NB, gappy);
    check("lat_edge1", int'(out_valid), 0);
    @(negedge clk);
    check("lat_edge2", int'(out_valid), 0);
    @(negedge clk);
    check("lat_edge3", int'(out_valid), 1);
    check("sum8", int'(out_sum), exp8);
    check("fire8", int'(out_fire), int'(exp8 >= thr));
    check("valid5", int'(out_valid5), 1);
    check("sum5", int'(out_sum5), exp5);
    check("fire5", int'(out_fire5), int'(exp5 >= t5));
    s8 = exp8; s5 = exp5; f8 = (exp8 >= thr); f5 = (exp5 >= t5);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      start = (i == 1);
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_sum", int'(out_sum), s8);
      check("hold_fire", int'(out_fire), int'(f8));
      check("hold_sum5", int'(out_sum5), s5);
      check("hold_fire5", int'(out_fire5), int'(f5));
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed_valid", int'(out_valid), 0);
    check("consumed_busy", int'(busy), 0);
    check("consumed_busy5", int'(busy5), 0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_fire", int'(out_fire), 0);
    rst_n = 1'b1;

    set_all(4'hF, 8'h00); run_eval(10, 1'b0, 5);
    set_all(4'hF, 8'hAA); run_eval(-16, 1'b0, 1);
    run_eval(-15, 1'b0, 2);
    set_all(4'hF, 8'h55); run_eval(0, 1'b1, 0);
    set_all(4'h0, 8'h00); run_eval(0, 1'b1, 3);
    set_all(4'hF, 8'h00); run_eval(16, 1'b0, 0);
    run_eval(17, 1'b0, 0);

    // Abort after two beats: block must return idle with nothing emitted.
    set_all(4'hF, 8'hAA);
    do_start(0);
    feed(2, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_fire", int'(out_fire), 0);
    check("abort_in_ready", int'(in_ready), 0);
    repeat (4) @(negedge clk);
    check("abort_quiet", int'(out_valid), 0);
    set_all(4'hF, 8'h00); run_eval(10, 1'b0, 0);

    // Asynchronous reset mid-accumulation clears outputs immediately.
    do_start(5);
    feed(2, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("amid_rst_busy", int'(busy), 0);
    check("amid_rst_in_ready", int'(in_ready), 0);
    check("amid_rst_out_sum", int'(out_sum), 0);
    check("amid_rst_out_fire", int'(out_fire), 0);
    check("amid_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_quiet", int'(out_valid), 0);

    for (int k = 0; k < 40; k++) begin
      set_random();
      t = int'($urandom_range(0, 40)) - 20;
      run_eval(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
